// File: rtl/spi_regfile_peripheral.sv
// SPI (CPHA=0) peripheral exposing NUM_REGS x DATA_W registers with write and read-back.
// SPI pins are oversampled in the clk domain; writes commit only on a well-formed frame.
module spi_regfile_peripheral #(
  parameter int SYNC     = 2,
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5,
  parameter int CPOL     = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         nCS,
  input  logic                         SCLK,
  input  logic                         COPI,
  output logic                         cipo,
  output logic                         cipo_oe,
  output logic [NUM_REGS*DATA_W-1:0]   regs,
  output logic                         wr_strobe,
  output logic [ADDR_W-1:0]            wr_addr,
  output logic                         frame_err,
  output logic [7:0]                   err_count
);

  localparam int FRAME = 1 + ADDR_W + DATA_W;
  localparam int CNT_W = $clog2(FRAME + 1);
  localparam logic CPOL_B = (CPOL != 0);
  localparam logic [ADDR_W:0]  NUM_REGS_W = (ADDR_W+1)'(NUM_REGS);
  localparam logic [CNT_W-1:0] LAST_CMD   = CNT_W'(ADDR_W);
  localparam logic [CNT_W-1:0] LAST_DATA  = CNT_W'(FRAME - 1);

  typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

  state_t state, state_d;

  logic [SYNC:0]   ncs_sync;
  logic [SYNC:0]   sclk_sync;
  logic [SYNC-1:0] copi_sync;

  logic [CNT_W-1:0]  cnt;
  logic [ADDR_W:0]   cmd;
  logic [ADDR_W:0]   cmd_nxt;
  logic [DATA_W-1:0] data_sr;
  logic [DATA_W-1:0] shadow;
  logic [DATA_W-1:0] rd_val;
  logic              overrun;

  logic [DATA_W-1:0] mem [NUM_REGS];

  logic ncs_s, ncs_fall, ncs_rise;
  logic sclk_rise, sclk_fall, lead, trail, lead_v, trail_v, copi_s;
  logic rw;
  logic [ADDR_W-1:0] addr;
  logic addr_ok;

  // Synchroniser stage: the two oldest taps feed edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ncs_sync  <= '1;
      sclk_sync <= {(SYNC+1){CPOL_B}};
      copi_sync <= '0;
    end else begin
      ncs_sync  <= {ncs_sync[SYNC-1:0], nCS};
      sclk_sync <= {sclk_sync[SYNC-1:0], SCLK};
      copi_sync <= {copi_sync[SYNC-2:0], COPI};
    end
  end

  assign ncs_s     = ncs_sync[SYNC-1];
  assign ncs_fall  = ncs_sync[SYNC] & ~ncs_s;
  assign ncs_rise  = ~ncs_sync[SYNC] & ncs_s;
  assign sclk_rise = ~sclk_sync[SYNC] & sclk_sync[SYNC-1];
  assign sclk_fall = sclk_sync[SYNC] & ~sclk_sync[SYNC-1];
  assign lead      = CPOL_B ? sclk_fall : sclk_rise;
  assign trail     = CPOL_B ? sclk_rise : sclk_fall;
  assign copi_s    = copi_sync[SYNC-1];

  // A chip-select rise in the same cycle masks any SCLK edge
  assign lead_v  = lead  & ~ncs_s & ~ncs_rise;
  assign trail_v = trail & ~ncs_s & ~ncs_rise;

  assign cmd_nxt = (ADDR_W+1)'({cmd, copi_s});
  assign rw      = cmd[ADDR_W];
  assign addr    = cmd[ADDR_W-1:0];
  assign addr_ok = ({1'b0, addr} < NUM_REGS_W);
  assign cipo_oe = ~ncs_s;

  always_comb begin
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (cmd_nxt[ADDR_W-1:0] == ADDR_W'(i)) rd_val = mem[i];
    end
  end

  // Frame FSM
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (ncs_rise) begin
      state_d = S_IDLE;
    end else begin
      case (state)
        S_IDLE: if (ncs_fall) state_d = S_CMD;
        S_CMD:  if (lead_v && cnt == LAST_CMD)  state_d = S_DATA;
        S_DATA: if (lead_v && cnt == LAST_DATA) state_d = S_DONE;
        S_DONE: state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Shift/sample stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt     <= '0;
      cmd     <= '0;
      data_sr <= '0;
      shadow  <= '0;
      overrun <= 1'b0;
      cipo    <= 1'b0;
    end else begin
      if (state == S_IDLE && ncs_fall) begin
        cnt     <= '0;
        cmd     <= '0;
        data_sr <= '0;
        shadow  <= '0;
        overrun <= 1'b0;
      end else if (lead_v) begin
        case (state)
          S_CMD: begin
            cnt <= cnt + 1'b1;
            cmd <= cmd_nxt;
            if (cnt == LAST_CMD) shadow <= rd_val;
          end
          S_DATA: begin
            cnt     <= cnt + 1'b1;
            data_sr <= DATA_W'({data_sr, copi_s});
          end
          S_DONE:  overrun <= 1'b1;
          default: ;
        endcase
      end

      if (state == S_DATA && !rw) begin
        if (trail_v) begin
          cipo   <= shadow[DATA_W-1];
          shadow <= DATA_W'({shadow, 1'b0});
        end
      end else begin
        cipo <= 1'b0;
      end
    end
  end

  // Commit stage: resolve the frame on the chip-select rise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) mem[i] <= '0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      frame_err <= 1'b0;
      err_count <= '0;
    end else begin
      wr_strobe <= 1'b0;
      frame_err <= 1'b0;
      if (ncs_rise) begin
        if (state == S_DONE && !overrun) begin
          if (rw && addr_ok) begin
            for (int i = 0; i < NUM_REGS; i++) begin
              if (addr == ADDR_W'(i)) mem[i] <= data_sr;
            end
            wr_strobe <= 1'b1;
            wr_addr   <= addr;
          end
        end else if (state != S_IDLE) begin
          frame_err <= 1'b1;
          if (err_count != 8'hFF) err_count <= err_count + 1'b1;
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_regs
    assign regs[g*DATA_W +: DATA_W] = mem[g];
  end

endmodule

// File: tb/tb_spi_regfile_peripheral.sv
// Directed bench: default-parameter instance (A) and CPOL=1/16-bit/8-register instance (B).
module tb_spi_regfile_peripheral;

  localparam int HALF = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic ncs_a, sclk_a, copi_a, cipo_a, oe_a, wrs_a, ferr_a;
  logic [39:0] regs_a;
  logic [6:0]  wra_a;
  logic [7:0]  errc_a;

  logic ncs_b, sclk_b, copi_b, cipo_b, oe_b, wrs_b, ferr_b;
  logic [127:0] regs_b;
  logic [6:0]   wra_b;
  logic [7:0]   errc_b;

  spi_regfile_peripheral dut_a (
    .clk(clk), .rst_n(rst_n), .nCS(ncs_a), .SCLK(sclk_a), .COPI(copi_a),
    .cipo(cipo_a), .cipo_oe(oe_a), .regs(regs_a), .wr_strobe(wrs_a),
    .wr_addr(wra_a), .frame_err(ferr_a), .err_count(errc_a)
  );

  spi_regfile_peripheral #(.DATA_W(16), .NUM_REGS(8), .CPOL(1)) dut_b (
    .clk(clk), .rst_n(rst_n), .nCS(ncs_b), .SCLK(sclk_b), .COPI(copi_b),
    .cipo(cipo_b), .cipo_oe(oe_b), .regs(regs_b), .wr_strobe(wrs_b),
    .wr_addr(wra_b), .frame_err(ferr_b), .err_count(errc_b)
  );

  int n_checks = 0;
  int n_errors = 0;
  int strobes_a = 0;
  int errs_a = 0;
  logic oe_seen;

  always @(posedge clk) begin
    if (wrs_a)  strobes_a <= strobes_a + 1;
    if (ferr_a) errs_a    <= errs_a + 1;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit sel, input logic cs, input logic sck, input logic d);
    if (sel) begin ncs_b = cs; sclk_b = sck; copi_b = d; end
    else     begin ncs_a = cs; sclk_a = sck; copi_a = d; end
  endtask

  // Sends bits[n-1:0] MSB first; rx collects cipo before each leading edge past the header.
  task automatic spi_xfer(input bit sel, input logic [31:0] bits, input int n, input bit keep_cs,
                          output logic [31:0] rx, output int lat);
    logic idle;
    logic ev;
    idle = sel;
    rx = '0;
    lat = 0;
    drive(sel, 1'b0, idle, bits[n-1]);
    for (int j = 0; j < n; j++) begin
      drive(sel, 1'b0, idle, bits[n-1-j]);
      tick(HALF);
      if (j == 0) oe_seen = sel ? oe_b : oe_a;
      if (j >= 8) rx = {rx[30:0], (sel ? cipo_b : cipo_a)};
      drive(sel, 1'b0, ~idle, bits[n-1-j]);
      tick(HALF);
      drive(sel, 1'b0, idle, bits[n-1-j]);
    end
    tick(HALF);
    if (!keep_cs) begin
      drive(sel, 1'b1, idle, 1'b0);
      for (int k = 1; k <= 12; k++) begin
        @(posedge clk);
        #1;
        ev = sel ? (wrs_b | ferr_b) : (wrs_a | ferr_a);
        if (ev && lat == 0) lat = k;
      end
      tick(6);
    end
  endtask

  logic [31:0] rx;
  int lat;
  int s0;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0);
    tick(3);
    check("rst_regs_a", regs_a, 0);
    check("rst_regs_b", regs_b, 0);
    check("rst_outs_a", {wrs_a, ferr_a, cipo_a, oe_a, wra_a, errc_a}, 0);
    rst_n = 1'b1;
    tick(4);
    check("idle_outs_a", {wrs_a, ferr_a, cipo_a, oe_a}, 0);

    // Write 0xAA to address 4
    spi_xfer(1'b0, 32'h84AA, 16, 1'b0, rx, lat);
    check("w4_regs", regs_a, 40'hAA_00_00_00_00);
    check("w4_latency", lat, 3);
    check("w4_strobes", strobes_a, 1);
    check("w4_wr_addr", wra_a, 4);
    check("w4_oe_mid", oe_seen, 1);
    check("w4_oe_after", oe_a, 0);

    // Write 0x5C to address 1, then read it back
    spi_xfer(1'b0, 32'h815C, 16, 1'b0, rx, lat);
    check("w1_regs", regs_a, 40'hAA_00_00_5C_00);
    s0 = strobes_a;
    spi_xfer(1'b0, 32'h0100, 16, 1'b0, rx, lat);
    check("r1_data", rx, 32'h5C);
    check("r1_regs", regs_a, 40'hAA_00_00_5C_00);
    check("r1_no_strobe", strobes_a - s0, 0);
    check("r1_no_event", lat, 0);
    check("r1_cipo_idle", cipo_a, 0);
    spi_xfer(1'b0, 32'h0400, 16, 1'b0, rx, lat);
    check("r4_data", rx, 32'hAA);

    // Short frame and overrun frame
    spi_xfer(1'b0, 32'h101, 9, 1'b0, rx, lat);
    check("short_latency", lat, 3);
    check("short_errc", errc_a, 1);
    spi_xfer(1'b0, 32'h100AB, 17, 1'b0, rx, lat);
    check("over_errc", errc_a, 2);
    check("over_pulses", errs_a, 2);
    check("bad_regs", regs_a, 40'hAA_00_00_5C_00);

    // Out-of-range address
    s0 = strobes_a;
    spi_xfer(1'b0, 32'h8733, 16, 1'b0, rx, lat);
    check("w7_no_event", lat, 0);
    check("w7_no_strobe", strobes_a - s0, 0);
    check("w7_wr_addr", wra_a, 1);
    spi_xfer(1'b0, 32'h0700, 16, 1'b0, rx, lat);
    check("r7_data", rx, 0);
    check("r7_errc", errc_a, 2);
    check("r7_regs", regs_a, 40'hAA_00_00_5C_00);

    // CPOL=1, 16-bit instance
    spi_xfer(1'b1, 32'h86BEEF, 24, 1'b0, rx, lat);
    check("b_w6_regs", regs_b, 128'h0000_BEEF_0000_0000_0000_0000_0000_0000);
    check("b_w6_latency", lat, 3);
    check("b_w6_wr_addr", wra_b, 6);
    spi_xfer(1'b1, 32'h060000, 24, 1'b0, rx, lat);
    check("b_r6_data", rx, 32'hBEEF);
    check("b_errc", errc_b, 0);

    // Reset in the middle of a write frame
    spi_xfer(1'b0, 32'h80FF, 16, 1'b0, rx, lat);
    check("w0_regs", regs_a, 40'hAA_00_00_5C_FF);
    spi_xfer(1'b0, 32'h200, 10, 1'b1, rx, lat);
    rst_n = 1'b0;
    tick(3);
    drive(1'b0, 1'b1, 1'b0, 1'b0);
    tick(3);
    rst_n = 1'b1;
    tick(6);
    check("mid_rst_regs_a", regs_a, 0);
    check("mid_rst_regs_b", regs_b, 0);
    check("mid_rst_errc", errc_a, 0);
    spi_xfer(1'b0, 32'h8212, 16, 1'b0, rx, lat);
    check("post_rst_regs", regs_a, 40'h00_00_12_00_00);
    check("post_rst_latency", lat, 3);
    check("post_rst_errc", errc_a, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
